// File: rtl/fpga_loader_pkg.sv
// Shared types for the fabric bitstream loader: FSM state encoding.
package fpga_loader_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    PRESET  = 3'd1,
    LOAD_LO = 3'd2,
    LOAD_HI = 3'd3,
    DONE    = 3'd4
  } loader_state_e;

endpackage

// File: rtl/fpga_loader_tail_check.sv
// Sticky chain-tail checker: any set tail bit seen on a sample cycle latches err until clear.
module fpga_loader_tail_check #(
  parameter int NUM_CHAINS = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  sample,
  input  logic [NUM_CHAINS-1:0] tail,
  output logic                  err
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (clear) begin
      err <= 1'b0;
    end else if (sample && (|tail)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: rtl/fpga_bitstream_loader.sv
// Configuration sequencer: presets the fabric, shifts one slice per prog_clk into all chains, then releases I/O.
// Optional tail checker built when FPGA_LOADER_TAIL_CHECK_EN is defined; otherwise tail_err is tied low.
module fpga_bitstream_loader
  import fpga_loader_pkg::*;
#(
  parameter int NUM_CHAINS    = 12,
  parameter int CHAIN_LEN     = 1024,
  parameter int PRESET_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  bs_valid,
  input  logic [NUM_CHAINS-1:0] bs_data,
  output logic                  bs_ready,
  output logic                  prog_clk,
  output logic                  pReset,
  output logic                  config_enable,
  output logic                  IO_ISOL_N,
  output logic [NUM_CHAINS-1:0] ccff_head,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic                  busy,
  output logic                  done,
  output logic                  tail_err
);

  localparam int BIT_W = $clog2(CHAIN_LEN + 1);
  localparam int PRE_W = $clog2(PRESET_CYCLES + 1);

  loader_state_e   state, state_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_inc;
  logic [PRE_W-1:0] pre_cnt, pre_cnt_inc;
  logic             accept;
  logic             kickoff;

  logic                  prog_clk_nxt;
  logic                  p_reset_nxt;
  logic                  busy_nxt;
  logic                  done_nxt;
  logic                  bs_ready_nxt;
  logic [NUM_CHAINS-1:0] head_nxt;

  assign bit_cnt_inc = bit_cnt + 1'b1;
  assign pre_cnt_inc = pre_cnt + 1'b1;
  assign accept      = bs_valid && bs_ready;
  assign kickoff     = (state_nxt == PRESET) && (state != PRESET);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are derived from the next state and registered, so they line up with the state they describe.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PRESET;
      PRESET:  if (pre_cnt_inc == PRE_W'(PRESET_CYCLES)) state_nxt = LOAD_LO;
      LOAD_LO: if (accept) state_nxt = LOAD_HI;
      LOAD_HI: state_nxt = (bit_cnt_inc == BIT_W'(CHAIN_LEN)) ? DONE : LOAD_LO;
      DONE:    if (start) state_nxt = PRESET;
      default: state_nxt = IDLE;
    endcase

    prog_clk_nxt = (state_nxt == LOAD_HI);
    bs_ready_nxt = (state_nxt == LOAD_LO);
    busy_nxt     = (state_nxt == PRESET) || (state_nxt == LOAD_LO) || (state_nxt == LOAD_HI);
    done_nxt     = (state_nxt == DONE);

    // pReset stays high out of reset until the first load has been through PRESET.
    p_reset_nxt = pReset;
    if (state_nxt == PRESET) begin
      p_reset_nxt = 1'b1;
    end else if (state == PRESET) begin
      p_reset_nxt = 1'b0;
    end

    head_nxt = ccff_head;
    if (state_nxt == DONE) begin
      head_nxt = '0;
    end else if (accept) begin
      head_nxt = bs_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prog_clk      <= 1'b0;
      pReset        <= 1'b1;
      config_enable <= 1'b0;
      IO_ISOL_N     <= 1'b0;
      ccff_head     <= '0;
      bs_ready      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      prog_clk      <= prog_clk_nxt;
      pReset        <= p_reset_nxt;
      config_enable <= busy_nxt;
      IO_ISOL_N     <= done_nxt;
      ccff_head     <= head_nxt;
      bs_ready      <= bs_ready_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      pre_cnt <= '0;
    end else if (kickoff) begin
      bit_cnt <= '0;
      pre_cnt <= '0;
    end else begin
      if (state == PRESET) pre_cnt <= pre_cnt_inc;
      if (state == LOAD_HI) bit_cnt <= bit_cnt_inc;
    end
  end

`ifdef FPGA_LOADER_TAIL_CHECK_EN
  fpga_loader_tail_check #(
    .NUM_CHAINS(NUM_CHAINS)
  ) u_tail_check (
    .clk    (clk),
    .rst    (reset),
    .clear  (kickoff),
    .sample (state == LOAD_HI),
    .tail   (ccff_tail),
    .err    (tail_err)
  );
`else
  logic unused_tail;
  assign unused_tail = ^ccff_tail;
  assign tail_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_bitstream_loader.sv
// Directed bench for fpga_bitstream_loader: accepted slices are queued and matched against each prog_clk pulse.
module tb_fpga_bitstream_loader;

  localparam int NC = 12;
  localparam int CL = 4;
  localparam int PC = 2;

`ifdef FPGA_LOADER_TAIL_CHECK_EN
  localparam bit TAIL_EN = 1'b1;
`else
  localparam bit TAIL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          bs_valid;
  logic [NC-1:0] bs_data;
  logic          bs_ready;
  logic          prog_clk;
  logic          pReset;
  logic          config_enable;
  logic          IO_ISOL_N;
  logic [NC-1:0] ccff_head;
  logic [NC-1:0] ccff_tail;
  logic          busy;
  logic          done;
  logic          tail_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NC-1:0] exp_q[$];
  logic [NC-1:0] words[CL];

  fpga_bitstream_loader #(
    .NUM_CHAINS   (NC),
    .CHAIN_LEN    (CL),
    .PRESET_CYCLES(PC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bs_valid     (bs_valid),
    .bs_data      (bs_data),
    .bs_ready     (bs_ready),
    .prog_clk     (prog_clk),
    .pReset       (pReset),
    .config_enable(config_enable),
    .IO_ISOL_N    (IO_ISOL_N),
    .ccff_head    (ccff_head),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .done         (done),
    .tail_err     (tail_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_prog_clk"}, prog_clk, 0);
    chk({tag, "_pReset"}, pReset, 1);
    chk({tag, "_config_enable"}, config_enable, 0);
    chk({tag, "_IO_ISOL_N"}, IO_ISOL_N, 0);
    chk({tag, "_ccff_head"}, ccff_head, 0);
    chk({tag, "_bs_ready"}, bs_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_tail_err"}, tail_err, 0);
  endtask

  // Runs one load from a start pulse; abort_at>0 asserts reset after that many prog_clk pulses.
  task automatic do_load(input string tag, input int stall_n, input bit mid_start,
                         input bit tail_inj, input int abort_at, input int exp_done);
    int cyc = 0;
    int idx = 0;
    int pulses = 0;
    int stalls_left;
    int done_cyc = -1;
    bit hs, stalled;
    bit prev_pclk = 1'b0;
    bit mid_sent = 1'b0;
    bit fin = 1'b0;
    bit aborted = 1'b0;
    logic [NC-1:0] w;

    stalls_left = stall_n;
    exp_q.delete();
    bs_data   = words[0];
    bs_valid  = 1'b1;
    ccff_tail = '0;
    start     = 1'b1;

    while (!fin && cyc < 100) begin
      hs      = bs_valid && bs_ready;
      stalled = bs_ready && !bs_valid;
      if (hs) exp_q.push_back(bs_data);
      @(posedge clk);
      #1;
      cyc++;
      start     = 1'b0;
      ccff_tail = '0;
      if (stalled) stalls_left--;
      if (hs) begin
        idx++;
        if (idx < CL) bs_data = words[idx];
      end
      bs_valid = (idx < CL) && !(idx == 1 && stalls_left > 0);

      if (cyc == 1) begin
        chk({tag, "_busy_c1"}, busy, 1);
        chk({tag, "_done_c1"}, done, 0);
        chk({tag, "_tail_err_c1"}, tail_err, 0);
      end
      if (cyc <= PC) chk({tag, "_preset_high"}, pReset, 1);
      if (cyc == PC + 1) begin
        chk({tag, "_preset_low"}, pReset, 0);
        chk({tag, "_first_ready"}, bs_ready, 1);
      end
      if (stalled) begin
        chk({tag, "_stall_prog_clk"}, prog_clk, 0);
        chk({tag, "_stall_head"}, ccff_head, words[0]);
      end
      if (prog_clk && !prev_pclk) begin
        pulses++;
        chk({tag, "_pulse_has_word"}, (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          chk({tag, "_head_at_pulse"}, ccff_head, w);
        end
        if (tail_inj && pulses == 3) ccff_tail = 12'h008;
      end
      prev_pclk = prog_clk;

      if (mid_start && !mid_sent && pulses == 1 && bs_ready) begin
        start    = 1'b1;
        mid_sent = 1'b1;
      end
      if (abort_at != 0 && pulses == abort_at && !prog_clk) begin
        aborted = 1'b1;
        fin     = 1'b1;
      end
      if (done) begin
        fin      = 1'b1;
        done_cyc = cyc;
      end
    end

    if (abort_at != 0) begin
      chk({tag, "_reached_abort"}, aborted, 1);
      reset = 1'b1;
      #1;
      check_reset_vals({tag, "_async"});
      @(posedge clk);
      #1;
      check_reset_vals({tag, "_edge"});
      exp_q.delete();
      bs_valid = 1'b0;
    end else begin
      chk({tag, "_done_cycle"}, done_cyc, exp_done);
      chk({tag, "_pulses"}, pulses, CL);
      chk({tag, "_io_released"}, IO_ISOL_N, 1);
      chk({tag, "_cfg_en_off"}, config_enable, 0);
      chk({tag, "_busy_off"}, busy, 0);
      chk({tag, "_head_cleared"}, ccff_head, 0);
      chk({tag, "_prog_clk_low"}, prog_clk, 0);
      chk({tag, "_queue_empty"}, exp_q.size(), 0);
      chk({tag, "_tail_err"}, tail_err, TAIL_EN && tail_inj);
    end
  endtask

  initial begin
    words[0] = 12'hA5A;
    words[1] = 12'h5A5;
    words[2] = 12'hFFF;
    words[3] = 12'h001;
    reset     = 1'b1;
    start     = 1'b0;
    bs_valid  = 1'b0;
    bs_data   = '0;
    ccff_tail = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals("rst_idle");

    do_load("clean", 0, 1'b0, 1'b0, 0, 1 + PC + 2 * CL);
    do_load("stall", 3, 1'b0, 1'b0, 0, 1 + PC + 2 * CL + 3);
    do_load("abort", 0, 1'b0, 1'b0, 2, 0);

    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals("post_abort");

    do_load("midstart", 0, 1'b1, 1'b0, 0, 1 + PC + 2 * CL);
    do_load("tail", 0, 1'b0, 1'b1, 0, 1 + PC + 2 * CL);
    repeat (3) @(posedge clk);
    #1;
    chk("tail_sticky", tail_err, TAIL_EN);
    chk("done_held", done, 1);
    do_load("reload", 0, 1'b0, 1'b0, 0, 1 + PC + 2 * CL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
